tinyspu_cmd_seq: RTL and testbench
==================================

# tinyspu_cmd_seq

Upstream command sequencer for the tiny SPU. A host pushes 16-bit command words into a small FIFO; the sequencer drives each one onto the SPU's `ui_in`/`uio_in` pins for a fixed number of cycles. For non-NoOp commands it then captures the SPU's `uo_out` result (M, N) and presents it on a valid/ready result port. This replaces hand-timed pin wiggling with a deterministic, back-pressured stream.

## Interface

Parameters:
- `DEPTH`, 8: command FIFO entries; power of two, ≥2.
- `HOLD_CYCLES`, 2: cycles each command is driven to the SPU; ≥1.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `cmd_data`  in  16  command `{op[15:12], q[11:8], data[7:0]}`; `data` is `{A/C, B/D}`.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  FIFO not full.
- `spu_ui_out`  out  8  to SPU `ui_in`: `{op, q}`.
- `spu_uio_out`  out  8  to SPU `uio_in`: `data`.
- `spu_uo_in`  in  8  from SPU `uo_out`: `{M, N}`.
- `res_data`  out  8  captured `{M, N}`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumer ready.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- `busy`  out  1  high when state ≠ IDLE or `level` ≠ 0.

## Operation

- **FIFO:**
  - Push on `cmd_valid && cmd_ready`.
  - `cmd_ready = (level != DEPTH)`.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves `level` unchanged.
  - A push to an empty FIFO is not visible to the sequencer until the next edge. There is no bypass.
- **States:** IDLE, HOLD, RESULT.
  - **IDLE:** `spu_ui_out = 0`, `spu_uio_out = 0` (NoOp, Q=0). If `level != 0`, pop the head into the issue register, set `hold_cnt = HOLD_CYCLES-1`, and go to HOLD.
  - **HOLD:** drive `spu_ui_out = {op, q}` and `spu_uio_out = data` from the issue register. Decrement `hold_cnt` each cycle. On the edge where `hold_cnt == 0`:
    - If `op != 0`: capture `spu_uo_in` into `res_data`, set `res_valid`, and go to RESULT.
    - Else, if FIFO non-empty: pop the next command and stay in HOLD (no bubble).
    - Else: go to IDLE.
  - **RESULT:** SPU outputs are 0. `res_valid = 1` and `res_data` stays stable until `res_valid && res_ready`. On that edge, clear `res_valid`, then pop the next command into HOLD if the FIFO is non-empty, else go to IDLE.
- `op == 0` commands (register loads via Q) never produce a result.
- `res_ready` is ignored while `res_valid = 0`.

## Timing

- Reset values: `cmd_ready = 1`, `level = 0`, `busy = 0`, `spu_ui_out = 0`, `spu_uio_out = 0`, `res_data = 0`, `res_valid = 0`, state IDLE, FIFO empty.
- Asserting `rst` at any time, including mid-HOLD or in RESULT, forces these values immediately and asynchronously. In-flight and queued commands are discarded.
- Latency:
  - A command pushed at edge N into an idle, empty block is driven from edge N+1 through edge N+1+HOLD_CYCLES.
  - Its result, if any, is valid from edge N+1+HOLD_CYCLES.
  - The SPU output is sampled on that same edge, i.e. after HOLD_CYCLES full cycles of stable input.
- Back-to-back no-result commands are issued with zero idle cycles between them.
- All outputs are registered; no combinational path from `cmd_valid` or `res_ready` to any output except through `level` and `cmd_ready` on the next edge.

## Configuration

- `TINYSPU_SEQ_CAPTURE_EN`
  - **Defined:** behaviour as above.
  - **Undefined:** the RESULT state and result register are not built. `res_data = 0`, `res_valid = 0`, and `res_ready` is ignored. Every command, regardless of `op`, follows the `op == 0` path at the end of HOLD.

## Test plan

- **Reset:** pulse `rst` → `cmd_ready = 1`, `level = 0`, `busy = 0`, `spu_ui_out = 0x00`, `spu_uio_out = 0x00`, `res_valid = 0`.
- **Load command:** push `0x0645` at edge N → `spu_ui_out = 0x06` and `spu_uio_out = 0x45` for edges N+1..N+2 (HOLD_CYCLES=2), then 0x00. `res_valid` stays 0.
- **Op with capture:** push `0x1000` with `spu_uo_in = 0x9B` → `spu_ui_out = 0x10` for 2 cycles. `res_data = 0x9B` and `res_valid = 1` from edge N+3, held while `res_ready = 0`, and cleared one edge after `res_ready = 1`.
- **Back-to-back loads:** push `0x0645` then `0x0567` on consecutive edges → the second is driven starting exactly 2 cycles after the first, with no 0x00 gap.
- **Full FIFO:** hold `res_ready = 0` and push 10 op commands → first pops, `level` reaches 8, `cmd_ready = 0`, and the tenth push is not accepted. Release `res_ready` → all 9 accepted results emerge in order.
- **Reset mid-HOLD:** assert `rst` during the first HOLD cycle with 3 queued commands → outputs go to 0x00 at once, `level = 0`. After release, nothing is issued.

Source files
------------

// File: rtl/tinyspu_cmd_seq.sv
// Command sequencer for the tiny SPU: a FIFO of 16-bit commands, each held on the SPU pins
// for HOLD_CYCLES cycles. Result capture and the RESULT state are built only when TINYSPU_SEQ_CAPTURE_EN is defined.
module tinyspu_cmd_seq #(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            cmd_data,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  output logic [7:0]             spu_ui_out,
  output logic [7:0]             spu_uio_out,
  input  logic [7:0]             spu_uo_in,
  output logic [7:0]             res_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, HOLD, RESULT} state_t;

  state_t        state, state_next;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [15:0]   head, issue, issue_next;
  logic [HW-1:0] hold_cnt, hold_next;
  logic          push, pop, hold_done, fifo_empty, want_result;

  assign cmd_ready   = (level != FULL_LEVEL);
  assign push        = cmd_valid && cmd_ready;
  assign fifo_empty  = (level == '0);
  assign head        = mem[rd_ptr];
  assign hold_done   = (hold_cnt == '0);
  assign spu_ui_out  = issue[15:8];
  assign spu_uio_out = issue[7:0];
  assign busy        = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_data;
  end

  // Occupancy is tracked separately from the pointers so full and empty never alias.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (hold_done) begin
          if (want_result)      state_next = RESULT;
          else if (!fifo_empty) pop = 1'b1;
          else                  state_next = IDLE;
        end
      end
`ifdef TINYSPU_SEQ_CAPTURE_EN
      RESULT: begin
        if (res_valid && res_ready) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = HOLD;
          end else begin
            state_next = IDLE;
          end
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // The issue register doubles as the pin driver, so anything outside HOLD reads as NoOp/Q=0.
  always_comb begin
    issue_next = 16'h0000;
    hold_next  = hold_cnt;
    if (pop) begin
      issue_next = head;
      hold_next  = HOLD_LOAD;
    end else if (state_next == HOLD) begin
      issue_next = issue;
      if (!hold_done) hold_next = hold_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue    <= 16'h0000;
      hold_cnt <= '0;
    end else begin
      issue    <= issue_next;
      hold_cnt <= hold_next;
    end
  end

`ifdef TINYSPU_SEQ_CAPTURE_EN
  assign want_result = (issue[15:12] != 4'd0);

  // The SPU output is sampled on the last HOLD edge, after HOLD_CYCLES cycles of stable input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data  <= 8'h00;
      res_valid <= 1'b0;
    end else if (state == HOLD && state_next == RESULT) begin
      res_data  <= spu_uo_in;
      res_valid <= 1'b1;
    end else if (state == RESULT && state_next != RESULT) begin
      res_valid <= 1'b0;
    end
  end
`else
  logic unused_inputs;

  assign want_result   = 1'b0;
  assign res_data      = 8'h00;
  assign res_valid     = 1'b0;
  assign unused_inputs = &{1'b0, spu_uo_in, res_ready};
`endif

endmodule

// File: tb/tb_tinyspu_cmd_seq.sv
// Randomised scoreboard bench for tinyspu_cmd_seq, with a queue-based model of command issue
// and a fake SPU whose output is a fixed function of the pins being driven.
module tb_tinyspu_cmd_seq;

  localparam int DEPTH       = 8;
  localparam int HOLD_CYCLES = 2;
`ifdef TINYSPU_SEQ_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  typedef struct {
    logic [15:0] cmd;
    int          accept_edge;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  spu_ui_out;
  logic [7:0]  spu_uio_out;
  logic [7:0]  spu_uo_in;
  logic [7:0]  res_data;
  logic        res_valid;
  logic        res_ready;
  logic [$clog2(DEPTH):0] level;
  logic        busy;

  int          checks = 0;
  int          fails = 0;
  int          edge_cnt = 0;
  entry_t      cmdq[$];
  logic [7:0]  res_q[$];
  logic        drv_active = 1'b0;
  logic        wait_res = 1'b0;
  logic [15:0] drv_cmd = 16'h0000;
  int          drv_left = 0;
  logic        try_start;
  entry_t      head_e;
  logic [15:0] rnd;

  tinyspu_cmd_seq #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .spu_ui_out (spu_ui_out),
    .spu_uio_out(spu_uio_out),
    .spu_uo_in  (spu_uo_in),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .level      (level),
    .busy       (busy)
  );

  function automatic logic [7:0] spuModel(input logic [7:0] ui, input logic [7:0] uio);
    return (ui + 8'h5A) ^ {uio[3:0], uio[7:4]};
  endfunction

  assign spu_uo_in = spuModel(spu_ui_out, spu_uio_out);

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Inputs change 1 time unit after the falling edge, after the model has stepped.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic rr);
    @(negedge clk);
    #1;
    cmd_valid = v;
    cmd_data  = d;
    res_ready = rr;
    if (v && cmdq.size() != DEPTH) begin
      entry_t e;
      e.cmd         = d;
      e.accept_edge = edge_cnt + 1;
      cmdq.push_back(e);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    checkOutput({tag, "_level"},     32'(level), 32'd0);
    checkOutput({tag, "_busy"},      32'(busy), 32'd0);
    checkOutput({tag, "_ui"},        32'(spu_ui_out), 32'd0);
    checkOutput({tag, "_uio"},       32'(spu_uio_out), 32'd0);
    checkOutput({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    checkOutput({tag, "_res_data"},  32'(res_data), 32'd0);
  endtask

  task automatic resetModel();
    cmdq.delete();
    res_q.delete();
    drv_active = 1'b0;
    wait_res   = 1'b0;
    drv_cmd    = 16'h0000;
    drv_left   = 0;
  endtask

  task automatic drainAll();
    int n = 0;
    while ((cmdq.size() != 0 || drv_active || wait_res) && n < 300) begin
      applyStimulus(1'b0, 16'h0000, 1'b1);
      n++;
    end
    checkOutput("drain_done", 32'(n < 300), 32'd1);
  endtask

  // Model: each accepted command is driven for HOLD_CYCLES edges, then either waits for its
  // result handshake or hands over to the next command that was accepted on an earlier edge.
  always @(negedge clk) begin
    if (!rst) begin
      try_start = 1'b0;
      if (drv_active) begin
        drv_left--;
        if (drv_left == 0) begin
          drv_active = 1'b0;
          if (CAP && drv_cmd[15:12] != 4'd0) begin
            wait_res = 1'b1;
            res_q.push_back(spuModel(drv_cmd[15:8], drv_cmd[7:0]));
          end else begin
            try_start = 1'b1;
          end
        end
      end else if (wait_res) begin
        if (res_ready) begin
          wait_res  = 1'b0;
          try_start = 1'b1;
        end
      end else begin
        try_start = 1'b1;
      end
      if (try_start && cmdq.size() != 0 && cmdq[0].accept_edge < edge_cnt) begin
        head_e     = cmdq.pop_front();
        drv_cmd    = head_e.cmd;
        drv_active = 1'b1;
        drv_left   = HOLD_CYCLES;
      end
      checkOutput("ui",        32'(spu_ui_out),  32'(drv_active ? drv_cmd[15:8] : 8'h00));
      checkOutput("uio",       32'(spu_uio_out), 32'(drv_active ? drv_cmd[7:0] : 8'h00));
      checkOutput("level",     32'(level),       32'(cmdq.size()));
      checkOutput("cmd_ready", 32'(cmd_ready),   32'(cmdq.size() != DEPTH));
      checkOutput("busy",      32'(busy),        32'(drv_active || wait_res || cmdq.size() != 0));
      checkOutput("res_valid", 32'(res_valid),   32'(wait_res));
      if (!CAP) checkOutput("res_data_off", 32'(res_data), 32'd0);
    end
  end

  // Result monitor: every cycle a result is presented it must match the oldest expected one.
  always @(negedge clk) begin
    #2;
    if (!rst && res_valid) begin
      if (res_q.size() == 0) begin
        checkOutput("res_unexpected", 32'(res_valid), 32'd0);
      end else begin
        checkOutput("res_data", 32'(res_data), 32'(res_q[0]));
        if (res_ready) void'(res_q.pop_front());
      end
    end
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 16'h0000;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("por");
    #3 rst = 1'b0;

    $display("[TB] single load command");
    applyStimulus(1'b1, 16'h0645, 1'b1);
    repeat (5) applyStimulus(1'b0, 16'h0000, 1'b1);

    $display("[TB] op command with held result");
    applyStimulus(1'b1, 16'h1000, 1'b0);
    repeat (6) applyStimulus(1'b0, 16'h0000, 1'b0);
    repeat (4) applyStimulus(1'b0, 16'h0000, 1'b1);

    $display("[TB] back-to-back loads");
    applyStimulus(1'b1, 16'h0645, 1'b1);
    applyStimulus(1'b1, 16'h0567, 1'b1);
    repeat (6) applyStimulus(1'b0, 16'h0000, 1'b1);

    $display("[TB] fill FIFO under back-pressure");
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, {4'(1 + i % 15), 4'(i), 8'(i * 17 + 3)}, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0);
`ifdef TINYSPU_SEQ_CAPTURE_EN
    checkOutput("full_level", 32'(level), 32'(DEPTH));
    checkOutput("full_ready", 32'(cmd_ready), 32'd0);
`endif
    drainAll();

    $display("[TB] randomised traffic");
    for (int i = 0; i < 400; i++) begin
      rnd = 16'($urandom);
      if ($urandom_range(0, 1) == 0) rnd[15:12] = 4'd0;
      applyStimulus($urandom_range(0, 99) < 60, rnd, $urandom_range(0, 1) == 1);
    end
    drainAll();

    $display("[TB] reset during HOLD with queued commands");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, {4'd0, 4'(i + 1), 8'(8'hA0 + i)}, 1'b1);
    @(negedge clk);
    #3;
    cmd_valid = 1'b0;
    rst       = 1'b1;
    #1;
    checkReset("mid_hold");
    resetModel();
    @(negedge clk);
    #3 rst = 1'b0;
    repeat (10) applyStimulus(1'b0, 16'h0000, 1'b1);

    checkOutput("res_q_empty", 32'(res_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
